i2c_slave_byte_rx: RTL and testbench

//  Downstream consumer of the START/STOP detector pulses. Tracks an I2C frame on

---
 rtl/i2c_pkg.sv | 36 +++
 rtl/i2c_slave_byte_rx_if.sv | 33 +++
 rtl/i2c_scl_edge.sv | 22 ++
 rtl/i2c_slave_byte_rx.sv | 150 +++++++++++++++
 tb/tb_i2c_slave_byte_rx.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM state encoding, field widths, bit-count
// constants and the masked address compare used by the slave receiver.
package i2c_pkg;

    localparam int I2C_ADDR_W = 7;
    localparam int I2C_BYTE_W = 8;
    localparam int I2C_CNT_W  = 4;

    // Number of data bits shifted before the ACK slot of every byte.
    localparam logic [I2C_CNT_W-1:0] I2C_ACK_CNT = 4'd8;

    // FSM state encoding (3 bits).
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_ADDR     = 3'd1;
    localparam logic [2:0] ST_ADDR_ACK = 3'd2;
    localparam logic [2:0] ST_DATA     = 3'd3;
    localparam logic [2:0] ST_DATA_ACK = 3'd4;
    localparam logic [2:0] ST_IGNORE   = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE     = ST_IDLE,
        S_ADDR     = ST_ADDR,
        S_ADDR_ACK = ST_ADDR_ACK,
        S_DATA     = ST_DATA,
        S_DATA_ACK = ST_DATA_ACK,
        S_IGNORE   = ST_IGNORE
    } i2c_state_t;

    // A mask bit of 1 means that address bit must equal the slave address.
    function automatic logic addr_matches(input logic [I2C_ADDR_W-1:0] a,
                                          input logic [I2C_ADDR_W-1:0] slave,
                                          input logic [I2C_ADDR_W-1:0] mask);
        return ((a ^ slave) & mask) == '0;
    endfunction

endpackage

// File: rtl/i2c_slave_byte_rx_if.sv
// Bus bundle between the START/STOP detector / pad logic and the slave byte
// receiver, plus the strobes handed to the address-translation stage.
interface i2c_slave_byte_rx_if;
    import i2c_pkg::*;

    logic                  sda_in;
    logic                  scl_in;
    logic                  start_detect;
    logic                  stop_detect;
    logic                  sda_oe;
    logic                  addr_valid;
    logic [I2C_ADDR_W-1:0] addr;
    logic                  rw;
    logic                  addr_match;
    logic                  data_valid;
    logic [I2C_BYTE_W-1:0] data;
    logic                  busy;

    // Receiver side.
    modport slave (
        input  sda_in, scl_in, start_detect, stop_detect,
        output sda_oe, addr_valid, addr, rw, addr_match,
        output data_valid, data, busy
    );

    // Driver / consumer side.
    modport master (
        output sda_in, scl_in, start_detect, stop_detect,
        input  sda_oe, addr_valid, addr, rw, addr_match,
        input  data_valid, data, busy
    );

endinterface

// File: rtl/i2c_scl_edge.sv
// SCL edge detector: registers the sampled SCL and produces single-cycle
// rise/fall pulses. The register resets high so an idle bus gives no edge.
module i2c_scl_edge (
    input  logic clk,
    input  logic rst,
    input  logic i_scl,
    output logic o_rise,
    output logic o_fall
);

    logic r_scl_d;

    // Previous-cycle copy of SCL.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_scl_d <= 1'b1;
        else     r_scl_d <= i_scl;
    end

    assign o_rise = ~r_scl_d &  i_scl;
    assign o_fall =  r_scl_d & ~i_scl;

endmodule

// File: rtl/i2c_slave_byte_rx.sv
// I2C slave byte receiver: follows a frame on sampled SCL/SDA, captures the
// address byte and write data bytes, and requests an ACK pull-down when the
// address matches under ADDR_MASK. sda_oe only moves on SCL-fall cycles,
// START/STOP or reset so it can never fake a START/STOP on the bus.
module i2c_slave_byte_rx
    import i2c_pkg::*;
#(
    parameter logic [I2C_ADDR_W-1:0] SLAVE_ADDR = 7'h50,
    parameter logic [I2C_ADDR_W-1:0] ADDR_MASK  = 7'h7F
) (
    input  logic              clk,
    input  logic              rst,
    i2c_slave_byte_rx_if.slave bus
);

    logic                  w_rise;
    logic                  w_fall;
    logic [I2C_BYTE_W-1:0] w_shift;

    i2c_state_t            r_state;
    logic [I2C_CNT_W-1:0]  r_cnt;
    logic [I2C_BYTE_W-1:0] r_sr;
    logic                  r_sda_oe;
    logic                  r_addr_valid;
    logic [I2C_ADDR_W-1:0] r_addr;
    logic                  r_rw;
    logic                  r_addr_match;
    logic                  r_data_valid;
    logic [I2C_BYTE_W-1:0] r_data;
    logic                  r_busy;

    i2c_scl_edge u_scl_edge (
        .clk    (clk),
        .rst    (rst),
        .i_scl  (bus.scl_in),
        .o_rise (w_rise),
        .o_fall (w_fall)
    );

    // Shift register contents after taking the current SDA bit, MSB first.
    assign w_shift = {r_sr[I2C_BYTE_W-2:0], bus.sda_in};

    // Frame FSM with shifter, bit counter and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_sr         <= '0;
            r_sda_oe     <= 1'b0;
            r_addr_valid <= 1'b0;
            r_addr       <= '0;
            r_rw         <= 1'b0;
            r_addr_match <= 1'b0;
            r_data_valid <= 1'b0;
            r_data       <= '0;
            r_busy       <= 1'b0;
        end else begin
            r_addr_valid <= 1'b0;
            r_data_valid <= 1'b0;

            if (bus.stop_detect) begin
                // STOP beats everything, including a coincident START.
                r_state  <= S_IDLE;
                r_sda_oe <= 1'b0;
                r_busy   <= 1'b0;
                r_cnt    <= '0;
                r_sr     <= '0;
            end else if (bus.start_detect) begin
                // START or repeated START: drop any partial byte.
                r_state  <= S_ADDR;
                r_sda_oe <= 1'b0;
                r_busy   <= 1'b1;
                r_cnt    <= '0;
                r_sr     <= '0;
            end else begin
                case (r_state)
                    S_ADDR, S_DATA: begin
                        if (w_rise && (r_cnt < I2C_ACK_CNT)) begin
                            r_sr  <= w_shift;
                            r_cnt <= r_cnt + 4'd1;
                            if (r_cnt == I2C_ACK_CNT - 4'd1) begin
                                if (r_state == S_ADDR) begin
                                    r_addr       <= w_shift[I2C_BYTE_W-1:1];
                                    r_rw         <= w_shift[0];
                                    r_addr_match <= addr_matches(w_shift[I2C_BYTE_W-1:1],
                                                                 SLAVE_ADDR, ADDR_MASK);
                                    r_addr_valid <= 1'b1;
                                end else begin
                                    r_data       <= w_shift;
                                    r_data_valid <= 1'b1;
                                end
                            end
                        end else if (w_fall && (r_cnt == I2C_ACK_CNT)) begin
                            if (r_state == S_DATA) begin
                                r_sda_oe <= 1'b1;
                                r_state  <= S_DATA_ACK;
                            end else if (r_addr_match) begin
                                r_sda_oe <= 1'b1;
                                r_state  <= S_ADDR_ACK;
                            end else begin
                                r_state  <= S_IGNORE;
                            end
                        end
                    end

                    S_ADDR_ACK: begin
                        if (w_fall) begin
                            r_sda_oe <= 1'b0;
                            if (!r_rw) begin
                                r_state <= S_DATA;
                                r_cnt   <= '0;
                                r_sr    <= '0;
                            end else begin
                                // Reads are not serviced by this block.
                                r_state <= S_IGNORE;
                            end
                        end
                    end

                    S_DATA_ACK: begin
                        if (w_fall) begin
                            r_sda_oe <= 1'b0;
                            r_state  <= S_DATA;
                            r_cnt    <= '0;
                            r_sr     <= '0;
                        end
                    end

                    S_IGNORE: begin
                        r_sda_oe <= 1'b0;
                    end

                    default: begin
                        // IDLE: only START/STOP matter.
                    end
                endcase
            end
        end
    end

    assign bus.sda_oe     = r_sda_oe;
    assign bus.addr_valid = r_addr_valid;
    assign bus.addr       = r_addr;
    assign bus.rw         = r_rw;
    assign bus.addr_match = r_addr_match;
    assign bus.data_valid = r_data_valid;
    assign bus.data       = r_data;
    assign bus.busy       = r_busy;

endmodule

// File: tb/tb_i2c_slave_byte_rx.sv
// Bench for i2c_slave_byte_rx: two instances (full mask and mask 7'h78) see
// the same bus. A frame-position model predicts every output each cycle.
module tb_i2c_slave_byte_rx;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    i2c_slave_byte_rx_if bif0 ();
    i2c_slave_byte_rx_if bif1 ();

    assign bif1.sda_in       = bif0.sda_in;
    assign bif1.scl_in       = bif0.scl_in;
    assign bif1.start_detect = bif0.start_detect;
    assign bif1.stop_detect  = bif0.stop_detect;

    i2c_slave_byte_rx #(.SLAVE_ADDR(7'h50), .ADDR_MASK(7'h7F)) dut0 (
        .clk (clk), .rst (rst), .bus (bif0));
    i2c_slave_byte_rx #(.SLAVE_ADDR(7'h50), .ADDR_MASK(7'h78)) dut1 (
        .clk (clk), .rst (rst), .bus (bif1));

    int n_tests = 0;
    int n_fail  = 0;

    // Model: frame position from rise count since START (9 clocks per byte).
    int         MK [2] = '{'h7F, 'h78};
    logic       m_scl_d;
    logic       m_in;
    int         m_nr;
    int         m_val;
    logic       e_oe [2];
    logic       e_av [2];
    logic [6:0] e_addr [2];
    logic       e_rw [2];
    logic       e_match [2];
    logic       e_dv [2];
    logic [7:0] e_data [2];
    logic       e_busy [2];

    always @(posedge clk or posedge rst) begin : model
        logic rise, fall;
        int   pos, j;
        if (rst) begin
            m_scl_d = 1'b1; m_in = 1'b0; m_nr = 0; m_val = 0;
            for (int k = 0; k < 2; k++) begin
                e_oe[k] = 0; e_av[k] = 0; e_addr[k] = 0; e_rw[k] = 0;
                e_match[k] = 0; e_dv[k] = 0; e_data[k] = 0; e_busy[k] = 0;
            end
        end else begin
            rise = !m_scl_d && bif0.scl_in;
            fall = m_scl_d && !bif0.scl_in;
            m_scl_d = bif0.scl_in;
            for (int k = 0; k < 2; k++) begin e_av[k] = 0; e_dv[k] = 0; end
            if (bif0.stop_detect) begin
                m_in = 0;
                for (int k = 0; k < 2; k++) begin e_busy[k] = 0; e_oe[k] = 0; end
            end else if (bif0.start_detect) begin
                m_in = 1; m_nr = 0; m_val = 0;
                for (int k = 0; k < 2; k++) begin e_busy[k] = 1; e_oe[k] = 0; end
            end else if (m_in) begin
                if (rise) begin
                    m_nr = m_nr + 1;
                    pos = (m_nr - 1) % 9;
                    j = (m_nr - 1) / 9;
                    if (pos < 8) m_val = (m_val * 2 + (bif0.sda_in ? 1 : 0)) % 256;
                    if (pos == 7) begin
                        for (int k = 0; k < 2; k++) begin
                            if (j == 0) begin
                                e_addr[k]  = 7'(m_val / 2);
                                e_rw[k]    = (m_val % 2) == 1;
                                e_match[k] = (((m_val / 2) ^ 'h50) & MK[k]) == 0;
                                e_av[k]    = 1;
                            end else if (e_match[k] && !e_rw[k]) begin
                                e_data[k] = 8'(m_val);
                                e_dv[k]   = 1;
                            end
                        end
                        m_val = 0;
                    end
                end
                if (fall) begin
                    j = (m_nr - 1) / 9;
                    for (int k = 0; k < 2; k++) begin
                        if (m_nr > 0 && (m_nr % 9) == 8)
                            e_oe[k] = (j == 0) ? e_match[k] : (e_match[k] && !e_rw[k]);
                        else
                            e_oe[k] = 0;
                    end
                end
            end
        end
    end

    // DUT-side activity log used by the literal checks.
    int         av_cnt = 0;
    int         dv_cnt = 0;
    logic [7:0] dv_log [64];
    logic       oe_seen0 = 0;
    logic       oe_seen1 = 0;

    function automatic logic [20:0] pack_act(input int k);
        if (k == 0)
            return {bif0.sda_oe, bif0.addr_valid, bif0.addr, bif0.rw, bif0.addr_match,
                    bif0.data_valid, bif0.data, bif0.busy};
        return {bif1.sda_oe, bif1.addr_valid, bif1.addr, bif1.rw, bif1.addr_match,
                bif1.data_valid, bif1.data, bif1.busy};
    endfunction

    task automatic cycle_check();
        logic [20:0] act, exp;
        if (rst) return;
        for (int k = 0; k < 2; k++) begin
            act = pack_act(k);
            exp = {e_oe[k], e_av[k], e_addr[k], e_rw[k], e_match[k],
                   e_dv[k], e_data[k], e_busy[k]};
            n_tests++;
            if (act !== exp) begin
                n_fail++;
                $display("FAIL cycle_dut%0d t=%0t got oe,av,addr,rw,m,dv,data,busy=%h want %h",
                         k, $time, act, exp);
            end
        end
        if (bif0.addr_valid) av_cnt++;
        if (bif0.data_valid) begin dv_log[dv_cnt % 64] = bif0.data; dv_cnt++; end
        if (bif0.sda_oe) oe_seen0 = 1;
        if (bif1.sda_oe) oe_seen1 = 1;
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cycle_check();
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic bus_start();
        if (!bif0.scl_in) begin
            bif0.sda_in = 1; tick(2);
            bif0.scl_in = 1; tick(3);
        end
        bif0.sda_in = 0; tick(2);
        bif0.start_detect = 1; tick(1);
        bif0.start_detect = 0; tick(1);
        bif0.scl_in = 0; tick(2);
    endtask

    task automatic bus_bit(input logic b);
        bif0.sda_in = b; tick(2);
        bif0.scl_in = 1; tick(3);
        bif0.scl_in = 0; tick(2);
    endtask

    task automatic bus_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) bus_bit(b[i]);
        bus_bit(1'b1);
    endtask

    task automatic bus_stop();
        bif0.sda_in = 0; tick(2);
        bif0.scl_in = 1; tick(3);
        bif0.sda_in = 1; tick(1);
        bif0.stop_detect = 1; tick(1);
        bif0.stop_detect = 0; tick(2);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin : main
        int a0, d0;
        bif0.sda_in = 1; bif0.scl_in = 1;
        bif0.start_detect = 0; bif0.stop_detect = 0;
        rst = 1;
        tick(3);
        rst = 0;
        tick(2);
        chk("reset_outputs", 32'(pack_act(0)), 0);
        chk("reset_busy", bif1.busy, 0);

        // Matching write address, ACK window.
        a0 = av_cnt; oe_seen0 = 0;
        bus_start(); chk("busy_after_start", bif0.busy, 1);
        bus_byte(8'hA0);
        chk("t1_av_count", av_cnt - a0, 1);
        chk("t1_addr", bif0.addr, 7'h50);
        chk("t1_rw", bif0.rw, 0);
        chk("t1_match", bif0.addr_match, 1);
        chk("t1_ack_seen", oe_seen0, 1);
        chk("t1_model_addr", e_addr[0], 7'h50);
        bus_stop();
        chk("t1_busy_after_stop", bif0.busy, 0);

        // Non-matching address: no ACK, no data strobe.
        d0 = dv_cnt; oe_seen0 = 0;
        bus_start(); bus_byte(8'hA2); bus_byte(8'h12); bus_stop();
        chk("t2_addr", bif0.addr, 7'h51);
        chk("t2_match", bif0.addr_match, 0);
        chk("t2_no_ack", oe_seen0, 0);
        chk("t2_no_dv", dv_cnt - d0, 0);

        // Two write data bytes.
        d0 = dv_cnt;
        bus_start(); bus_byte(8'hA0); bus_byte(8'h3C); bus_byte(8'hFF); bus_stop();
        chk("t3_dv_count", dv_cnt - d0, 2);
        chk("t3_data0", dv_log[d0 % 64], 8'h3C);
        chk("t3_data1", dv_log[(d0 + 1) % 64], 8'hFF);

        // Partial byte then repeated START with a read address.
        d0 = dv_cnt; a0 = av_cnt;
        bus_start(); bus_byte(8'hA0);
        bus_bit(1); bus_bit(0); bus_bit(1); bus_bit(1);
        bus_start(); bus_byte(8'hA1);
        chk("t4_rw", bif0.rw, 1);
        chk("t4_busy", bif0.busy, 1);
        oe_seen0 = 0;
        bus_byte(8'h55);
        chk("t4_no_ack_read", oe_seen0, 0);
        bus_stop();
        chk("t4_no_dv", dv_cnt - d0, 0);
        chk("t4_av_count", av_cnt - a0, 2);

        // Masked compare: 0x57 matches under 7'h78 only.
        oe_seen0 = 0; oe_seen1 = 0;
        bus_start(); bus_byte(8'hAE); bus_stop();
        chk("t5_mask_match", bif1.addr_match, 1);
        chk("t5_full_nomatch", bif0.addr_match, 0);
        chk("t5_mask_ack", oe_seen1, 1);
        chk("t5_full_noack", oe_seen0, 0);
        chk("t5_model_match", e_match[1], 1);

        // Asynchronous reset while ACK is driven.
        bus_start();
        for (int i = 7; i >= 0; i--) bus_bit(i == 5 || i == 7);
        chk("t6_ack_before_rst", bif0.sda_oe, 1);
        #2 rst = 1;
        #1;
        chk("t6_async_oe", bif0.sda_oe, 0);
        chk("t6_async_busy", bif0.busy, 0);
        bif0.sda_in = 1; bif0.scl_in = 1;
        tick(2);
        rst = 0;
        tick(2);
        oe_seen0 = 0;
        bus_start(); bus_byte(8'hA0); bus_stop();
        chk("t6_ack_after_rst", oe_seen0, 1);
        chk("t6_match_after_rst", bif0.addr_match, 1);

        // Random frames against the model.
        for (int f = 0; f < 40; f++) begin
            int sel, nb;
            logic [6:0] ad;
            logic [7:0] b;
            sel = $urandom_range(0, 4);
            case (sel)
                0: ad = 7'h50;
                1: ad = 7'h51;
                2: ad = 7'h57;
                3: ad = 7'h5F;
                default: ad = 7'($urandom);
            endcase
            b = {ad, ($urandom_range(0, 3) == 0)};
            bus_start(); bus_byte(b);
            nb = $urandom_range(0, 3);
            for (int i = 0; i < nb; i++) bus_byte(8'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                int pb;
                pb = $urandom_range(1, 6);
                for (int i = 0; i < pb; i++) bus_bit(1'($urandom));
                bus_start();
                bus_byte({7'h50, 1'b0});
                bus_byte(8'($urandom));
            end
            bus_stop();
        end
        tick(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
